// File: rtl/wb_mux_arbiter.sv
// Round-robin arbiter and sequencer for the shared WIDTH-bit 2:1 writeback mux.
// Source 1 (ALU result) and source 2 (data-memory load) compete for the path.
// The granted source's byte is captured into a registered output stage with a
// valid/ready handshake. A burst cap (MAX_HOLD) bounds how long one source may
// hold the path while the other is waiting.
module wb_mux_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             req2,
    input  logic [WIDTH-1:0] data2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             sel,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_e;

    localparam logic [4:0] MAX_HOLD_C = 5'(MAX_HOLD);

    state_e           state_q, state_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    // 1: source 1 was the last to lose the grant; 0: source 2 (reset value).
    logic             last1_q, last1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;

    logic             load_en;
    logic             own_req;
    logic             other_req;
    logic             xfer;
    logic [4:0]       hold_inc;
    state_e           other_gnt;

    assign gnt1      = (state_q == GNT1);
    assign gnt2      = (state_q == GNT2);
    assign sel       = gnt1;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    // Handshake qualifiers: which request belongs to the holder and whether a beat moves.
    always_comb begin
        load_en   = !out_valid_q || out_ready;
        own_req   = 1'b0;
        other_req = 1'b0;
        other_gnt = IDLE;
        case (state_q)
            GNT1: begin
                own_req   = req1;
                other_req = req2;
                other_gnt = GNT2;
            end
            GNT2: begin
                own_req   = req2;
                other_req = req1;
                other_gnt = GNT1;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
                other_gnt = IDLE;
            end
        endcase
        xfer     = own_req && load_en;
        hold_inc = {1'b0, hold_cnt_q} + 5'd1;
    end

    // Grant FSM next state, burst counter and round-robin history.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last1_d    = last1_q;
        case (state_q)
            IDLE: begin
                if (req1 && req2) begin
                    state_d = last1_q ? GNT2 : GNT1;
                end else if (req1) begin
                    state_d = GNT1;
                end else if (req2) begin
                    state_d = GNT2;
                end
            end
            GNT1, GNT2: begin
                if (!own_req) begin
                    state_d    = other_req ? other_gnt : IDLE;
                    hold_cnt_d = '0;
                    last1_d    = (state_q == GNT1);
                end else if (xfer) begin
                    // A count already saturated at the cap still yields, so a
                    // source that starts requesting late is never starved.
                    if ((hold_inc >= MAX_HOLD_C) && other_req) begin
                        state_d    = other_gnt;
                        hold_cnt_d = '0;
                        last1_d    = (state_q == GNT1);
                    end else if (hold_inc > MAX_HOLD_C) begin
                        hold_cnt_d = MAX_HOLD_C[3:0];
                    end else begin
                        hold_cnt_d = hold_inc[3:0];
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Output register: capture on transfer, retire the beat when downstream takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel ? data1 : data2;
            out_src_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last1_q     <= last1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

endmodule

// File: tb/tb_wb_mux_arbiter.sv
// Directed bench for wb_mux_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1)
// share one stimulus. Source models present queued bytes and advance on
// consumption; expected beats go into a scoreboard queue when stimulus is set up.
module tb_wb_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req1 = 1'b0;
    logic       req2 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic       out_ready;

    logic       gnt1_a, gnt2_a, sel_a, ov_a, os_a;
    logic [7:0] od_a;
    logic       gnt1_b, gnt2_b, sel_b, ov_b, os_b;
    logic [7:0] od_b;

    logic       use_b;
    logic       mon_on;
    logic       m_gnt1, m_gnt2, m_sel, m_ov, m_os;
    logic [7:0] m_od;

    logic [7:0] s1q[$];
    logic [7:0] s2q[$];
    logic       s1_en, s2_en;
    logic [8:0] exp_q[$];

    int unsigned n_chk   = 0;
    int unsigned n_fail  = 0;
    int unsigned n_extra = 0;

    wb_mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req1(req1), .data1(data1), .req2(req2), .data2(data2),
        .gnt1(gnt1_a), .gnt2(gnt2_a), .sel(sel_a),
        .out_ready(out_ready), .out_valid(ov_a), .out_data(od_a), .out_src(os_a)
    );

    wb_mux_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n),
        .req1(req1), .data1(data1), .req2(req2), .data2(data2),
        .gnt1(gnt1_b), .gnt2(gnt2_b), .sel(sel_b),
        .out_ready(out_ready), .out_valid(ov_b), .out_data(od_b), .out_src(os_b)
    );

    always_comb begin
        m_gnt1 = use_b ? gnt1_b : gnt1_a;
        m_gnt2 = use_b ? gnt2_b : gnt2_a;
        m_sel  = use_b ? sel_b  : sel_a;
        m_ov   = use_b ? ov_b   : ov_a;
        m_od   = use_b ? od_b   : od_a;
        m_os   = use_b ? os_b   : os_a;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic src, input logic [7:0] d);
        exp_q.push_back({src, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present();
        req1  = s1_en && (s1q.size() != 0);
        data1 = (s1q.size() != 0) ? s1q[0] : 8'h00;
        req2  = s2_en && (s2q.size() != 0);
        data2 = (s2q.size() != 0) ? s2q[0] : 8'h00;
    endtask

    // Requester model: a byte is consumed when gnt && req && load_en at an edge.
    task automatic source_loop();
        logic c1, c2;
        forever begin
            @(negedge clk);
            c1 = m_gnt1 && req1 && (!m_ov || out_ready);
            c2 = m_gnt2 && req2 && (!m_ov || out_ready);
            @(posedge clk);
            #1;
            if (c1 && s1q.size() != 0) s1q.delete(0);
            if (c2 && s2q.size() != 0) s2q.delete(0);
            #1;
            present();
        end
    endtask

    // Scoreboard consumer: each accepted output beat is popped and compared.
    task automatic monitor_loop();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (mon_on && rst_n && m_ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_extra++;
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_beat", {23'd0, m_os, m_od}, {23'd0, e});
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_extra"}, n_extra, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s1_en = 1'b0;
        s2_en = 1'b0;
        s1q.delete();
        s2q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] g1pat;
        logic [7:0] s3_od [1:6];

        rst_n     = 1'b0;
        out_ready = 1'b1;
        s1_en     = 1'b0;
        s2_en     = 1'b0;
        use_b     = 1'b0;
        mon_on    = 1'b0;
        fork
            source_loop();
            monitor_loop();
        join_none

        // Reset state of both instances
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt1_a", gnt1_a, 0); chk("rst_gnt2_a", gnt2_a, 0); chk("rst_sel_a", sel_a, 0);
        chk("rst_ov_a", ov_a, 0);     chk("rst_od_a", od_a, 0);     chk("rst_os_a", os_a, 0);
        chk("rst_gnt1_b", gnt1_b, 0); chk("rst_gnt2_b", gnt2_b, 0); chk("rst_sel_b", sel_b, 0);
        chk("rst_ov_b", ov_b, 0);     chk("rst_od_b", od_b, 0);     chk("rst_os_b", os_b, 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Single request latency: grant after 1 cycle, beat visible after 2
        tick();
        s1q.push_back(8'hA5); push_exp(1'b1, 8'hA5); s1_en = 1'b1;
        @(negedge clk);
        chk("s1_pre_gnt1", m_gnt1, 0);
        @(negedge clk);
        chk("s1_c1_gnt1", m_gnt1, 1); chk("s1_c1_sel", m_sel, 1); chk("s1_c1_ov", m_ov, 0);
        @(negedge clk);
        chk("s1_c2_ov", m_ov, 1); chk("s1_c2_od", m_od, 8'hA5); chk("s1_c2_os", m_os, 1);
        drain("s1");

        // Simultaneous requests with MAX_HOLD=4: 4 beats each, no bubble
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) s1q.push_back(8'(8'h11 + i));
        for (int i = 0; i < 5; i++) s2q.push_back(8'(8'h21 + i));
        for (int i = 0; i < 4; i++) push_exp(1'b1, 8'(8'h11 + i));
        for (int i = 0; i < 4; i++) push_exp(1'b0, 8'(8'h21 + i));
        push_exp(1'b1, 8'h15); push_exp(1'b1, 8'h16); push_exp(1'b0, 8'h25);
        s1_en = 1'b1; s2_en = 1'b1;
        @(negedge clk);
        g1pat = 10'b1100001111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("s2_gnt1_c%0d", k), m_gnt1, 32'(g1pat[k]));
            chk($sformatf("s2_gnt2_c%0d", k), m_gnt2, 32'(!g1pat[k]));
        end
        drain("s2");

        // Stall on source 2: output holds, nothing lost or duplicated
        do_reset();
        tick();
        s2q.push_back(8'h10); s2q.push_back(8'h11); s2q.push_back(8'h12);
        push_exp(1'b0, 8'h10); push_exp(1'b0, 8'h11); push_exp(1'b0, 8'h12);
        s2_en = 1'b1;
        s3_od[1] = 8'h10; s3_od[2] = 8'h10; s3_od[3] = 8'h10;
        s3_od[4] = 8'h10; s3_od[5] = 8'h11; s3_od[6] = 8'h12;
        tick();
        @(negedge clk);
        chk("s3_c0_gnt2", m_gnt2, 1); chk("s3_c0_ov", m_ov, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) out_ready = 1'b0;
            if (k == 4) out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("s3_ov_c%0d", k), m_ov, 1);
            chk($sformatf("s3_od_c%0d", k), m_od, 32'(s3_od[k]));
            if (k <= 4) chk($sformatf("s3_gnt2_c%0d", k), m_gnt2, 1);
        end
        drain("s3");

        // Source 1 drops after 2 beats while source 2 waits
        do_reset();
        tick();
        s1q.push_back(8'h31); s1q.push_back(8'h32);
        s2q.push_back(8'h41); s2q.push_back(8'h42);
        push_exp(1'b1, 8'h31); push_exp(1'b1, 8'h32);
        push_exp(1'b0, 8'h41); push_exp(1'b0, 8'h42);
        s1_en = 1'b1; s2_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("s4_gnt1_c%0d", k), m_gnt1, 32'(k < 3));
            chk($sformatf("s4_gnt2_c%0d", k), m_gnt2, 32'(k == 3));
        end
        drain("s4a");

        // Source 1 alone drops to IDLE, so the next tie goes to source 2
        tick();
        s1q.push_back(8'h51); s1q.push_back(8'h52);
        push_exp(1'b1, 8'h51); push_exp(1'b1, 8'h52);
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("s4b_idle_gnt1", m_gnt1, 0); chk("s4b_idle_gnt2", m_gnt2, 0);
        tick();
        s1q.push_back(8'h61); s2q.push_back(8'h71);
        push_exp(1'b0, 8'h71); push_exp(1'b1, 8'h61);
        @(negedge clk);
        @(negedge clk);
        chk("s4b_tie_gnt2", m_gnt2, 1); chk("s4b_tie_gnt1", m_gnt1, 0);
        drain("s4b");

        // Asynchronous reset mid-burst
        do_reset();
        tick();
        for (int i = 0; i < 8; i++) s1q.push_back(8'(8'h81 + i));
        push_exp(1'b1, 8'h81); push_exp(1'b1, 8'h82);
        s1_en = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("s5_pre_ov", m_ov, 1); chk("s5_pre_gnt1", m_gnt1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_async_gnt1", m_gnt1, 0); chk("s5_async_gnt2", m_gnt2, 0);
        chk("s5_async_sel", m_sel, 0);   chk("s5_async_ov", m_ov, 0);
        chk("s5_sb_empty", 32'(exp_q.size()), 32'd0);
        s1_en = 1'b0; s2_en = 1'b0;
        s1q.delete(); s2q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        s1q.push_back(8'h91); s2q.push_back(8'hA1);
        push_exp(1'b1, 8'h91); push_exp(1'b0, 8'hA1);
        s1_en = 1'b1; s2_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s5_tie_gnt1", m_gnt1, 1); chk("s5_tie_gnt2", m_gnt2, 0);
        drain("s5");

        // MAX_HOLD=1 instance: strict alternation
        use_b = 1'b1;
        do_reset();
        tick();
        s1q.push_back(8'h01); s1q.push_back(8'h01);
        s2q.push_back(8'h02); s2q.push_back(8'h02);
        push_exp(1'b1, 8'h01); push_exp(1'b0, 8'h02);
        push_exp(1'b1, 8'h01); push_exp(1'b0, 8'h02);
        s1_en = 1'b1; s2_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("s6_gnt1_c%0d", k), m_gnt1, 32'(k % 2 == 0));
        end
        drain("s6");
        chk("final_extra", n_extra, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mux_arbiter.md
Name: wb_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 8-bit 2:1 operand/writeback mux (Sel=1 passes In1, Sel=0 passes In2).
- Two requesters share the mux: source 1 (ALU result) and source 2 (data-memory load).
- The block grants one source at a time, drives the mux select, and captures the selected byte into a registered output stage with a valid/ready handshake toward the accumulator/register-file write port.
- A burst cap bounds how long one source can hold the path while the other waits.

Parameters:
- WIDTH, 8, data width of both sources and the output.
- MAX_HOLD, 4, maximum consecutive beats a granted source may transfer while the other source is requesting. Legal range 1..15.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req1  input  1  source 1 requests the path; data1 must be stable while req1 is high.
- data1  input  WIDTH  source 1 byte (mux In1).
- req2  input  1  source 2 requests the path.
- data2  input  WIDTH  source 2 byte (mux In2).
- gnt1  output  1  source 1 holds the grant (registered).
- gnt2  output  1  source 2 holds the grant (registered).
- sel  output  1  mux select: 1 exactly when gnt1 is high, else 0.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data/out_src hold a captured beat.
- out_data  output  WIDTH  captured byte.
- out_src  output  1  1 if the captured beat came from source 1, 0 if from source 2.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, gnt1=gnt2=sel=0, hold_cnt=0, last=2.
  - out_valid=0, out_data=0, out_src=0.
- States:
  - IDLE, GNT1, GNT2.
  - gnt1=(state==GNT1), gnt2=(state==GNT2), sel=gnt1.
- Internal signals:
  - load_en = !out_valid || out_ready.
  - A beat transfers in a cycle iff the granted source's req is high and load_en is 1.
  - The requester treats "gntX && reqX && load_en" at a rising edge as consumed; it then presents its next byte or drops req.
- IDLE transitions:
  - req1 only -> GNT1.
  - req2 only -> GNT2.
  - Both requesting -> grant the source that is not 'last' (after reset, source 1 wins the first tie).
  - Neither requesting -> stay in IDLE.
- GNTx transitions (y is the other source):
  - reqx low -> GNTy if reqy is high, else IDLE. No beat transfers in that cycle.
  - Beat transfers, hold_cnt+1==MAX_HOLD and reqy high -> GNTy; hold_cnt=0.
  - Beat transfers, otherwise -> stay in GNTx; hold_cnt increments, saturating at MAX_HOLD.
  - No transfer (stall, out_valid && !out_ready) with reqx high -> stay; hold_cnt frozen.
- On every grant change: hold_cnt=0 and 'last' is set to the source losing the grant.
- Output stage:
  - On transfer: out_data <= (sel ? data1 : data2), out_src <= sel, out_valid <= 1.
  - No transfer and out_ready high: out_valid <= 0; out_data/out_src hold their values.
  - Full throughput: transfers on consecutive cycles are allowed when out_ready stays high.
- Latency:
  - Request asserted while IDLE -> gnt high on the next cycle.
  - That cycle's transfer -> out_valid high on the cycle after. Total 2 cycles from req to out_valid.
  - Back-to-back beats within a grant: 1 beat/cycle.
- Switchover: one grant per cycle; the grant moves directly GNT1<->GNT2 with no idle bubble when the other source is waiting.
- Reset mid-burst: all state clears immediately; any captured beat is dropped (out_valid=0). Requesters re-arbitrate from IDLE with source 1 winning the first tie.
- Protocol violation: dropping reqx while stalled is tolerated; the grant moves per the GNTx rules and no beat is lost from the output register.
- MAX_HOLD=1: strict alternation every beat while both sources request.

Test Plan:
- Reset, then req1=1 with data1=8'hA5 held and out_ready=1 -> gnt1=1, sel=1 at cycle 1; out_valid=1, out_data=A5, out_src=1 at cycle 2.
- req1 and req2 raised in the same cycle after reset, both held, MAX_HOLD=4, out_ready=1 -> 4 beats from source 1, then gnt2 on the next cycle with no bubble, 4 beats from source 2, then back to source 1.
- GNT2 active, data2 stream 10,11,12, out_ready=0 for 3 cycles after the first beat -> out_data holds 10, gnt2 stays high, hold_cnt frozen; releasing out_ready delivers 11 then 12 in order with none lost or duplicated.
- Source 1 drops req1 after 2 beats while req2 is high -> gnt2 on the next cycle; 'last'=1; a subsequent simultaneous request grants source 2.
- Assert rst_n=0 mid-burst with out_valid=1 -> gnt1, gnt2, sel and out_valid all low immediately, without waiting for a clock edge; after release, simultaneous requests grant source 1.
- MAX_HOLD=1, both sources held, data1=8'h01, data2=8'h02 -> out_data sequence 01,02,01,02 with out_src 1,0,1,0.
